pipeline_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline.
- Merges stall requests from IF, ID, EX and MEM into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Sequences exception flushes and branch-mispredict flushes, holding either one off while a multi-cycle stall is in flight, and supplies the redirect PC.

---
 rtl/pipeline_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush controller for the 5-stage pipeline.
//   - Merges stall requests (mem > ex > id > if) into a 6-bit stall vector:
//     [0] pc, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
//   - Issues a full flush for exceptions/ERET and a front-end flush for
//     branch mispredicts, deferring either one while the stage that must
//     complete first is still stalled. It also supplies the redirect PC.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stallreq_if/id/ex/mem    per-stage stall requests
//   excepttype_i             MEM-stage exception type (0 = none)
//   cp0_epc_i                CP0 EPC, used as the ERET target
//   mispredict_i             EX-stage branch mispredict
//   mispredict_target_i      correct branch target
//   stall                    6-bit stall vector (1 = hold that stage)
//   flush                    full-pipeline flush (one-cycle pulse)
//   flush_bp                 front-end flush for a mispredict (one-cycle pulse)
//   new_pc                   redirect PC, zero unless flush or flush_bp
//   perf_sel_i, perf_cnt_o   stall-cause counter select / readback
//
// Configuration macro: STALL_PERF_CNT_EN enables four saturating stall-cause
//   counters (0=if, 1=id, 2=ex, 3=mem). perf_cnt_o is the selected counter,
//   registered. Without the macro perf_cnt_o is tied to zero.
//
// stall/flush/flush_bp/new_pc are combinational so that a redirect acts in
// the same cycle as its request. They are forced to zero while rst is low.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] EXC_BASE  = 32'h0000_0020,
    parameter logic [31:0]       ERET_CODE = 32'h0000_000e,
    parameter int                CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic [31:0]       excepttype_i,
    input  logic [ADDR_W-1:0] cp0_epc_i,
    input  logic              mispredict_i,
    input  logic [ADDR_W-1:0] mispredict_target_i,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              flush_bp,
    output logic [ADDR_W-1:0] new_pc,
    input  logic [1:0]        perf_sel_i,
    output logic [CNT_W-1:0]  perf_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EXC_HOLD = 2'd1,
        BP_HOLD  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] latch_pc_r;
    logic [ADDR_W-1:0] latch_pc_nxt_s;
    logic [5:0]        prio_stall_s;
    logic [5:0]        stall_s;
    logic              flush_s;
    logic              flush_bp_s;
    logic [ADDR_W-1:0] new_pc_s;
    logic              exc_s;
    logic [ADDR_W-1:0] exc_target_s;
    // The mispredict can only be resolved once the branch has left EX
    // and nothing downstream is holding the pipe.
    logic              bp_clear_s;

    // Priority-encoded stall vector: the deepest requesting stage wins.
    function automatic logic [5:0] prio_stall(input logic mem, input logic ex,
                                              input logic id, input logic fe);
        logic [5:0] v;
        if (mem) begin
            v = 6'b011111;
        end else if (ex) begin
            v = 6'b001111;
        end else if (id) begin
            v = 6'b000111;
        end else if (fe) begin
            v = 6'b000011;
        end else begin
            v = 6'b000000;
        end
        return v;
    endfunction

    assign prio_stall_s = prio_stall(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
    assign exc_s        = (excepttype_i != 32'h0000_0000);
    assign exc_target_s = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_BASE;
    assign bp_clear_s   = !stallreq_ex && !stallreq_mem;

    // Next-state and redirect decode.
    always_comb begin
        state_nxt_s    = state_r;
        latch_pc_nxt_s = latch_pc_r;
        stall_s        = prio_stall_s;
        flush_s        = 1'b0;
        flush_bp_s     = 1'b0;
        new_pc_s       = {ADDR_W{1'b0}};
        case (state_r)
            RUN, BP_HOLD: begin
                if (exc_s) begin
                    // Exceptions win over any fresh or pending mispredict.
                    if (!stallreq_mem) begin
                        flush_s     = 1'b1;
                        stall_s     = 6'b000000;
                        new_pc_s    = exc_target_s;
                        state_nxt_s = RUN;
                    end else begin
                        latch_pc_nxt_s = exc_target_s;
                        state_nxt_s    = EXC_HOLD;
                    end
                end else if (state_r == BP_HOLD) begin
                    if (bp_clear_s) begin
                        flush_bp_s  = 1'b1;
                        stall_s     = 6'b000000;
                        new_pc_s    = latch_pc_r;
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = BP_HOLD;
                    end
                end else if (mispredict_i) begin
                    // id/if requests come from wrong-path instructions.
                    if (bp_clear_s) begin
                        flush_bp_s = 1'b1;
                        stall_s    = 6'b000000;
                        new_pc_s   = mispredict_target_i;
                    end else begin
                        latch_pc_nxt_s = mispredict_target_i;
                        state_nxt_s    = BP_HOLD;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            EXC_HOLD: begin
                // New exception types are ignored until the held one retires.
                if (!stallreq_mem) begin
                    flush_s     = 1'b1;
                    stall_s     = 6'b000000;
                    new_pc_s    = latch_pc_r;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = EXC_HOLD;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // FSM state and latched redirect target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= RUN;
            latch_pc_r <= {ADDR_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            latch_pc_r <= latch_pc_nxt_s;
        end
    end

    assign stall    = rst ? stall_s    : 6'b000000;
    assign flush    = rst ? flush_s    : 1'b0;
    assign flush_bp = rst ? flush_bp_s : 1'b0;
    assign new_pc   = rst ? new_pc_s   : {ADDR_W{1'b0}};

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_r [4];
    logic [CNT_W-1:0] perf_r;
    logic             win_valid_s;
    logic [1:0]       win_idx_s;

    // Identify which request wins stall priority this cycle.
    always_comb begin
        win_valid_s = 1'b1;
        win_idx_s   = 2'd0;
        if (stallreq_mem) begin
            win_idx_s = 2'd3;
        end else if (stallreq_ex) begin
            win_idx_s = 2'd2;
        end else if (stallreq_id) begin
            win_idx_s = 2'd1;
        end else if (stallreq_if) begin
            win_idx_s = 2'd0;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Saturating cause counters and registered readback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            perf_r <= {CNT_W{1'b0}};
        end else begin
            if (win_valid_s && (cnt_r[win_idx_s] != {CNT_W{1'b1}})) begin
                cnt_r[win_idx_s] <= cnt_r[win_idx_s] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r[win_idx_s] <= cnt_r[win_idx_s];
            end
            perf_r <= cnt_r[perf_sel_i];
        end
    end

    assign perf_cnt_o = perf_r;
`else
    logic unused_perf_sel_s;
    assign unused_perf_sel_s = ^perf_sel_i;
    assign perf_cnt_o        = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_if = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic [31:0] excepttype_i = 32'h0;
    logic [31:0] cp0_epc_i = 32'h0;
    logic        mispredict_i = 1'b0;
    logic [31:0] mispredict_target_i = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic        flush_bp;
    logic [31:0] new_pc;
    logic [1:0]  perf_sel_i = 2'd0;
    logic [31:0] perf_cnt_o;

    int checks = 0;
    int failures = 0;

    // Reference model: an optional pending redirect (kind + PC).
    localparam int P_NONE = 0;
    localparam int P_EXC  = 1;
    localparam int P_BP   = 2;
    int          pend_kind = P_NONE;
    logic [31:0] pend_pc   = 32'h0;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
        .mispredict_i(mispredict_i), .mispredict_target_i(mispredict_target_i),
        .stall(stall), .flush(flush), .flush_bp(flush_bp), .new_pc(new_pc),
        .perf_sel_i(perf_sel_i), .perf_cnt_o(perf_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mem, input logic ex, input logic id, input logic fe,
                         input logic [31:0] exc, input logic [31:0] epc,
                         input logic mp, input logic [31:0] tgt);
        stallreq_mem = mem; stallreq_ex = ex; stallreq_id = id; stallreq_if = fe;
        excepttype_i = exc; cp0_epc_i = epc; mispredict_i = mp; mispredict_target_i = tgt;
    endtask

    // One clock: compare at negedge against the model, then advance the model.
    task automatic cyc(input string tag);
        logic [5:0]  e_stall;
        logic        e_flush, e_bp;
        logic [31:0] e_pc, exc_tgt;
        int          nk;
        logic [31:0] npc;
        @(negedge clk);
        e_flush = 1'b0; e_bp = 1'b0; e_pc = 32'h0; nk = pend_kind; npc = pend_pc;
        e_stall = stallreq_mem ? 6'd31 : stallreq_ex ? 6'd15 : stallreq_id ? 6'd7 :
                  stallreq_if ? 6'd3 : 6'd0;
        exc_tgt = (excepttype_i == 32'he) ? cp0_epc_i : 32'h20;
        if (pend_kind == P_EXC) begin
            if (!stallreq_mem) begin
                e_flush = 1'b1; e_pc = pend_pc; e_stall = 6'd0; nk = P_NONE;
            end
        end else if (excepttype_i != 32'h0) begin
            if (!stallreq_mem) begin
                e_flush = 1'b1; e_pc = exc_tgt; e_stall = 6'd0; nk = P_NONE;
            end else begin
                nk = P_EXC; npc = exc_tgt;
            end
        end else if (pend_kind == P_BP) begin
            if (!stallreq_ex && !stallreq_mem) begin
                e_bp = 1'b1; e_pc = pend_pc; e_stall = 6'd0; nk = P_NONE;
            end
        end else if (mispredict_i) begin
            if (!stallreq_ex && !stallreq_mem) begin
                e_bp = 1'b1; e_pc = mispredict_target_i; e_stall = 6'd0;
            end else begin
                nk = P_BP; npc = mispredict_target_i;
            end
        end
        chk({tag, ".stall"}, {26'h0, stall}, {26'h0, e_stall});
        chk({tag, ".flush"}, {31'h0, flush}, {31'h0, e_flush});
        chk({tag, ".flush_bp"}, {31'h0, flush_bp}, {31'h0, e_bp});
        chk({tag, ".new_pc"}, new_pc, e_pc);
        @(posedge clk);
        pend_kind = nk; pend_pc = npc;
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".stall"}, {26'h0, stall}, 32'h0);
        chk({tag, ".flush"}, {31'h0, flush}, 32'h0);
        chk({tag, ".flush_bp"}, {31'h0, flush_bp}, 32'h0);
        chk({tag, ".new_pc"}, new_pc, 32'h0);
        chk({tag, ".perf"}, perf_cnt_o, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        #1 rst = 1'b0;
        #1 check_zero(tag);
        pend_kind = P_NONE; pend_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        // Power-on reset, with stall requests active to prove gating.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 32'h44);
        #2 check_zero("por");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cyc("idle");

        // Stall priority.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0); cyc("id_if");
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0); cyc("mem_id_if");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0); cyc("ex_if");
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0); cyc("if_only");

        // Immediate exception and ERET.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0); cyc("exc_now");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); cyc("exc_after");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'h400, 1'b0, 32'h0); cyc("eret");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); cyc("eret_after");

        // Exception held behind a MEM stall; a new type during hold is ignored.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0); cyc("exch0");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'he, 32'h999, 1'b0, 32'h0); cyc("exch1");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); cyc("exch2");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); cyc("exch_rel");
        cyc("exch_after");

        // Mispredict held behind EX stall, then immediate one with id stall.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1000); cyc("bph0");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (3) cyc("bph");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); cyc("bp_rel");
        cyc("bp_after");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2000); cyc("bp_id");

        // Mispredict and exception in the same cycle: exception wins.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 32'h3000); cyc("exc_bp_same");

        // Exception takes over a pending mispredict.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1000); cyc("bp_pend");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0); cyc("bp_exc");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (3) cyc("bp_dropped");

        // Reset in EXC_HOLD drops the pending flush.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0); cyc("hold_pre_rst");
        do_reset("rst_in_hold");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (2) cyc("after_rst");

`ifdef STALL_PERF_CNT_EN
        do_reset("rst_perf");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (5) cyc("perf_ex");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        perf_sel_i = 2'd2;
        cyc("perf_idle");
        chk("perf_ex_cnt", perf_cnt_o, 32'd5);
        perf_sel_i = 2'd0;
`else
        chk("perf_tied", perf_cnt_o, 32'h0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] exc;
            int r;
            r = int'($urandom_range(0, 19));
            exc = (r == 0) ? 32'h8 : (r == 1) ? 32'he : (r == 2) ? ($urandom | 32'h1) : 32'h0;
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  exc, $urandom, $urandom_range(0, 5) == 0, $urandom);
            perf_sel_i = 2'($urandom_range(0, 3));
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
